gcd_arbiter: RTL

// - Shares one gcd engine (subtract/swap, start/done interface) among N requesters.
// - Round-robin arbitration; latches the winner's operands and pulses the engine start.
// - Waits for the engine's done, captures the result and returns it with a valid/ready handshake.
// - Sits between the requesting client blocks and a single gcd instance.

---
 rtl/gcd_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one start/done gcd engine among NUM_REQ clients.
// Optional WAIT-state watchdog enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   a_in,
    input  logic [NUM_REQ*DATA_W-1:0]   b_in,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        busy,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    output logic [DATA_W-1:0]           eng_a,
    output logic [DATA_W-1:0]           eng_b,
    output logic                        eng_start,
    input  logic [DATA_W-1:0]           eng_result,
    input  logic                        eng_done
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        RESP
    } state_t;

    state_t              state, state_nx;
    logic [ID_W-1:0]     rr, rr_nx;
    logic [ID_W-1:0]     win, hi_idx, lo_idx;
    logic                hi_found, lo_found;
    logic [NUM_REQ-1:0]  gnt_nx;
    logic                start_nx, busy_nx, valid_nx;
    logic [ID_W-1:0]     id_nx;
    logic [DATA_W-1:0]   data_nx, a_nx, b_nx;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                err_q, err_nx;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Lowest asserted index at/above rr wins, else lowest below rr.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (ID_W'(i) >= rr) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(i);
                end
            end
        end
        win = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_nx = state;
        rr_nx    = rr;
        gnt_nx   = '0;
        start_nx = 1'b0;
        valid_nx = rsp_valid;
        id_nx    = rsp_id;
        data_nx  = rsp_data;
        a_nx     = eng_a;
        b_nx     = eng_b;
`ifdef GCD_ARB_TIMEOUT_EN
        cnt_nx   = cnt;
        err_nx   = err_q;
`endif
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nx    = LOAD;
                    id_nx       = win;
                    a_nx        = a_in[win*DATA_W +: DATA_W];
                    b_nx        = b_in[win*DATA_W +: DATA_W];
                    gnt_nx[win] = 1'b1;
                    start_nx    = 1'b1;
                end
            end
            LOAD: begin
                state_nx = WAIT;
                rr_nx    = (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
                cnt_nx   = '0;
`endif
            end
            WAIT: begin
                if (eng_done) begin
                    state_nx = RESP;
                    valid_nx = 1'b1;
                    data_nx  = eng_result;
`ifdef GCD_ARB_TIMEOUT_EN
                    err_nx   = 1'b0;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nx = RESP;
                    valid_nx = 1'b1;
                    data_nx  = '0;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx   = cnt + 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr        <= '0;
            gnt       <= '0;
            eng_start <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            eng_a     <= '0;
            eng_b     <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt       <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            rr        <= rr_nx;
            gnt       <= gnt_nx;
            eng_start <= start_nx;
            busy      <= busy_nx;
            rsp_valid <= valid_nx;
            rsp_id    <= id_nx;
            rsp_data  <= data_nx;
            eng_a     <= a_nx;
            eng_b     <= b_nx;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt       <= cnt_nx;
            err_q     <= err_nx;
`endif
        end
    end

endmodule
